siggen: RTL and testbench

Configurable test-signal source producing a signed `sig`/`sig_valid` sample stream. It is the source side of the statistics monitor interface. It drives constant, ramp, triangle or pseudo-random patterns at a programmable sample rate, with an optional sample-count limit. Known bounds let the downstream min/max/count monitor be checked in-system. It sits in the baseband datapath ahead of the statistics monitor and DAC/DSP muxes, and is controlled from registers.

---
 rtl/siggen_pkg.sv | 33 +++
 rtl/siggen_lfsr.sv | 28 ++
 rtl/siggen.sv | 229 ++++++++++++++++++++++
 tb/tb_siggen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/siggen_pkg.sv
// siggen_pkg: shared types and constants for the siggen test-signal source.
// Holds the mode and state enumerations, the Galois LFSR tap mask, the
// default LFSR seed and the single-step LFSR helper used by siggen_lfsr.
package siggen_pkg;

    typedef enum logic [1:0] {
        CONST    = 2'd0,
        RAMP     = 2'd1,
        TRIANGLE = 2'd2,
        LFSR     = 2'd3
    } siggen_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } siggen_state_e;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] SIGGEN_LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] SIGGEN_DEFAULT_SEED = 32'hACE1_0001;

    // One Galois step: shift right, fold the tap mask in when a one drops out
    function automatic logic [31:0] siggen_lfsr_next(input logic [31:0] value);
        logic [31:0] shifted;
        shifted = value >> 1;
        if (value[0]) begin
            shifted = shifted ^ SIGGEN_LFSR_TAPS;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/siggen_lfsr.sv
// siggen_lfsr: 32-bit Galois LFSR used by siggen for its pseudo-random mode.
// load restarts the sequence from seed; advance steps it once. load wins.
// Only instantiated when SIGGEN_LFSR_EN is defined.
module siggen_lfsr
    import siggen_pkg::*;
#(
    parameter logic [31:0] SEED = SIGGEN_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    // LFSR register: reloaded at each run start, stepped once per emitted sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= SEED;
        end else if (load) begin
            value <= seed;
        end else if (advance) begin
            value <= siggen_lfsr_next(value);
        end
    end

endmodule

// File: rtl/siggen.sv
// siggen: configurable signed test-signal source (CONST, RAMP, TRIANGLE, LFSR)
// with a programmable sample spacing and an optional sample-count limit.
// Configuration is captured when a run starts, so register writes made while
// running do not disturb the stream.
// Build option: define SIGGEN_LFSR_EN to compile in the LFSR mode; without it
// mode 3 behaves as CONST and no LFSR state exists.
module siggen
    import siggen_pkg::*;
#(
    parameter int          WIDTH = 32,
    parameter logic [31:0] SEED  = SIGGEN_DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] step,
    input  logic [15:0]      rate,
    input  logic [31:0]      limit,
    output logic [WIDTH-1:0] sig,
    output logic             sig_valid,
    output logic [31:0]      count,
    output logic             done
);

    // Two guard bits keep cur +/- step exact for any signed cur and unsigned step
    localparam int XW = WIDTH + 2;

    siggen_state_e      state_q, state_d;
    siggen_mode_e       mode_q, mode_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   step_q, step_d;
    logic [15:0]        rate_q, rate_d;
    logic [31:0]        limit_q, limit_d;
    logic [WIDTH-1:0]   cur_q, cur_d;
    logic               down_q, down_d;
    logic [15:0]        div_q, div_d;
    logic [WIDTH-1:0]   sig_d;
    logic               sig_valid_d;
    logic [31:0]        count_d;
    logic               done_d;

    logic               start;
    logic               emit;
    logic [WIDTH-1:0]   sample_value;
    logic [WIDTH-1:0]   cur_next;
    logic               down_next;
    siggen_mode_e       mode_in;

    logic signed [XW-1:0] cur_x;
    logic signed [XW-1:0] lo_x;
    logic signed [XW-1:0] hi_x;
    logic signed [XW-1:0] step_x;
    logic signed [XW-1:0] up_x;
    logic signed [XW-1:0] dn_x;
    logic                 degenerate;

    assign cur_x      = {{2{cur_q[WIDTH-1]}}, cur_q};
    assign lo_x       = {{2{lo_q[WIDTH-1]}}, lo_q};
    assign hi_x       = {{2{hi_q[WIDTH-1]}}, hi_q};
    assign step_x     = {2'b00, step_q};
    assign up_x       = cur_x + step_x;
    assign dn_x       = cur_x - step_x;
    assign degenerate = (step_q == '0) || (lo_x > hi_x);

`ifdef SIGGEN_LFSR_EN
    logic [31:0] lfsr_value;

    siggen_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (start),
        .advance (emit),
        .seed    (SEED),
        .value   (lfsr_value)
    );

    assign mode_in      = siggen_mode_e'(mode);
    assign sample_value = (mode_q == LFSR) ? lfsr_value[WIDTH-1:0] : cur_q;
`else
    logic seed_unused;

    assign seed_unused  = ^SEED;
    assign mode_in      = (siggen_mode_e'(mode) == LFSR) ? CONST : siggen_mode_e'(mode);
    assign sample_value = cur_q;
`endif

    // Next waveform value: ramp wraps to lo, triangle reflects off hi/lo with clamping
    always_comb begin
        cur_next  = lo_q;
        down_next = down_q;
        case (mode_q)
            RAMP: begin
                if (!degenerate) begin
                    cur_next = (up_x > hi_x) ? lo_q : up_x[WIDTH-1:0];
                end
            end
            TRIANGLE: begin
                if (!degenerate) begin
                    if (!down_q) begin
                        if (up_x > hi_x) begin
                            down_next = 1'b1;
                            cur_next  = (dn_x < lo_x) ? lo_q : dn_x[WIDTH-1:0];
                        end else begin
                            cur_next  = up_x[WIDTH-1:0];
                        end
                    end else begin
                        if (dn_x < lo_x) begin
                            down_next = 1'b0;
                            cur_next  = (up_x > hi_x) ? hi_q : up_x[WIDTH-1:0];
                        end else begin
                            cur_next  = dn_x[WIDTH-1:0];
                        end
                    end
                end
            end
            default: begin
                cur_next = lo_q;
            end
        endcase
    end

    // Control FSM: capture config on start, pace samples with the divider, stop at limit
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        step_d      = step_q;
        rate_d      = rate_q;
        limit_d     = limit_q;
        cur_d       = cur_q;
        down_d      = down_q;
        div_d       = div_q;
        sig_d       = sig;
        sig_valid_d = 1'b0;
        count_d     = count;
        done_d      = done;
        start       = 1'b0;
        emit        = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    start   = 1'b1;
                    state_d = RUN;
                    mode_d  = mode_in;
                    lo_d    = lo;
                    hi_d    = hi;
                    step_d  = step;
                    rate_d  = rate;
                    limit_d = limit;
                    cur_d   = lo;
                    down_d  = 1'b0;
                    div_d   = rate;
                    count_d = '0;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (div_q == rate_q) begin
                    emit        = 1'b1;
                    sig_d       = sample_value;
                    sig_valid_d = 1'b1;
                    div_d       = '0;
                    count_d     = (count == '1) ? count : count + 32'd1;
                    cur_d       = cur_next;
                    down_d      = down_next;
                    if ((limit_q != '0) && (count_d == limit_q)) begin
                        state_d = DONE;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            DONE: begin
                done_d = 1'b1;
                if (!enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured configuration and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= CONST;
            lo_q      <= '0;
            hi_q      <= '0;
            step_q    <= '0;
            rate_q    <= '0;
            limit_q   <= '0;
            cur_q     <= '0;
            down_q    <= 1'b0;
            div_q     <= '0;
            sig       <= '0;
            sig_valid <= 1'b0;
            count     <= '0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            step_q    <= step_d;
            rate_q    <= rate_d;
            limit_q   <= limit_d;
            cur_q     <= cur_d;
            down_q    <= down_d;
            div_q     <= div_d;
            sig       <= sig_d;
            sig_valid <= sig_valid_d;
            count     <= count_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_siggen.sv
// tb_siggen: scoreboard bench for siggen. Each run's expected samples (value,
// running count, arrival cycle) are generated by a behavioural model and
// queued; a negedge monitor pops and compares on every sig_valid strobe.
module tb_siggen;

`ifdef SIGGEN_LFSR_EN
    localparam bit LFSR_ON = 1'b1;
`else
    localparam bit LFSR_ON = 1'b0;
`endif

    localparam logic [31:0] TB_SEED = 32'hACE1_0001;
    localparam int BUDGET = 3000;

    typedef struct {
        longint val;
        longint cnt;
        longint cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] lo = '0;
    logic [31:0] hi = '0;
    logic [31:0] step = '0;
    logic [15:0] rate = '0;
    logic [31:0] limit = '0;
    logic [31:0] sig;
    logic        sig_valid;
    logic [31:0] count;
    logic        done;

    exp_t   sb[$];
    longint cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;

    siggen #(.WIDTH(32), .SEED(TB_SEED)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .lo        (lo),
        .hi        (hi),
        .step      (step),
        .rate      (rate),
        .limit     (limit),
        .sig       (sig),
        .sig_valid (sig_valid),
        .count     (count),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && sig_valid) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_valid", longint'(sig_valid), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sig", longint'($signed(sig)), e.val);
                checkOutput("count", longint'(count), e.cnt);
                checkOutput("timing", cyc, e.cyc);
            end
        end
    end

    // Behavioural model of the sample sequence, straight from the waveform rules
    task automatic buildExpect(input int m, input logic [31:0] l32, input logic [31:0] h32,
                               input logic [31:0] s32, input int r, input int n, input longint first_cyc);
        longint l, h, s, cur;
        logic [31:0] lf;
        bit going_down;
        exp_t e;
        l = longint'($signed(l32));
        h = longint'($signed(h32));
        s = longint'({32'd0, s32});
        cur = l;
        lf = TB_SEED;
        going_down = 1'b0;
        for (int k = 0; k < n; k++) begin
            e.val = (m == 3 && LFSR_ON) ? longint'($signed(lf)) : cur;
            e.cnt = k + 1;
            e.cyc = first_cyc + longint'(k) * (r + 1);
            sb.push_back(e);
            lf = lf[0] ? ((lf >> 1) ^ 32'h8020_0003) : (lf >> 1);
            if ((m == 1 || m == 2) && s != 0 && l <= h) begin
                if (m == 1) begin
                    cur = (cur + s > h) ? l : cur + s;
                end else if (!going_down) begin
                    if (cur + s > h) begin
                        going_down = 1'b1;
                        cur = (cur - s < l) ? l : cur - s;
                    end else begin
                        cur = cur + s;
                    end
                end else begin
                    if (cur - s < l) begin
                        going_down = 1'b0;
                        cur = (cur + s > h) ? h : cur + s;
                    end else begin
                        cur = cur - s;
                    end
                end
            end else begin
                cur = l;
            end
        end
    endtask

    task automatic waitDrain();
        int t;
        for (t = 0; t < BUDGET; t++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        if (t == BUDGET) begin
            checkOutput("drain_timeout", longint'(sb.size()), 0);
            sb.delete();
        end
    endtask

    // Start a run, queue its expectations, then scramble the inputs mid-run
    task automatic startRun(input int m, input logic [31:0] l, input logic [31:0] h,
                            input logic [31:0] s, input int r, input logic [31:0] lim, input int n);
        @(negedge clk);
        mode = m[1:0];
        lo = l;
        hi = h;
        step = s;
        rate = r[15:0];
        limit = lim;
        enable = 1'b1;
        buildExpect(m, l, h, s, r, n, cyc + 2);
        @(negedge clk);
        mode = 2'($urandom_range(3));
        lo = $urandom;
        hi = $urandom;
        step = $urandom;
        rate = 16'($urandom_range(7));
        limit = 32'($urandom_range(5));
    endtask

    task automatic applyStimulus(input int m, input logic [31:0] l, input logic [31:0] h,
                                 input logic [31:0] s, input int r, input logic [31:0] lim, input int n);
        int nsamp;
        nsamp = (lim != 0) ? int'(lim) : n;
        startRun(m, l, h, s, r, lim, nsamp);
        waitDrain();
        if (lim != 0) begin
            checkOutput("done_early", longint'(done), 0);
            @(negedge clk);
            #1;
            checkOutput("done_rise", longint'(done), 1);
            checkOutput("count_final", longint'(count), longint'(lim));
            repeat (r + 4) @(negedge clk);
            checkOutput("done_hold", longint'(done), 1);
            enable = 1'b0;
        end else begin
            enable = 1'b0;
            repeat (r + 4) @(negedge clk);
            #1;
            checkOutput("count_held", longint'(count), longint'(nsamp));
            checkOutput("valid_idle", longint'(sig_valid), 0);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        $display("[TB] siggen scoreboard bench, LFSR mode compiled: %0d", LFSR_ON);
        #2;
        checkOutput("reset_sig", longint'(sig), 0);
        checkOutput("reset_valid", longint'(sig_valid), 0);
        checkOutput("reset_count", longint'(count), 0);
        checkOutput("reset_done", longint'(done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        applyStimulus(1, 32'd0, 32'd10, 32'd3, 0, 32'd8, 0);
        applyStimulus(2, -32'sd4, 32'd4, 32'd3, 2, 32'd7, 0);
        applyStimulus(0, -32'sd5, 32'd0, 32'd1, 9, 32'd0, 5);
        applyStimulus(3, 32'd7, 32'd20, 32'd2, 0, 32'd3, 0);
        applyStimulus(3, 32'd7, 32'd20, 32'd2, 0, 32'd2, 0);
        applyStimulus(3, 32'd7, 32'd20, 32'd2, 1, 32'd2, 0);
        applyStimulus(1, 32'd5, 32'd50, 32'd0, 1, 32'd4, 0);
        applyStimulus(2, 32'd9, -32'sd9, 32'd2, 0, 32'd4, 0);
        applyStimulus(1, 32'h7FFF_FFF0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 32'd3, 0);
        applyStimulus(2, 32'h7FFF_FFF0, 32'h7FFF_FFFF, 32'd8, 0, 32'd6, 0);
        applyStimulus(2, 32'h8000_0000, 32'h8000_0010, 32'd8, 1, 32'd6, 0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(int'($urandom_range(3)),
                          32'(int'($urandom_range(100)) - 50),
                          32'(int'($urandom_range(100)) - 50),
                          32'($urandom_range(20)),
                          int'($urandom_range(4)),
                          32'($urandom_range(1, 12)), 0);
        end

        // Asynchronous reset in the middle of an unbounded ramp
        startRun(1, 32'd1, 32'd100, 32'd2, 0, 32'd0, 3);
        waitDrain();
        sb.delete();
        enable = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("arst_sig", longint'(sig), 0);
        checkOutput("arst_valid", longint'(sig_valid), 0);
        checkOutput("arst_count", longint'(count), 0);
        checkOutput("arst_done", longint'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        applyStimulus(1, 32'd0, 32'd10, 32'd3, 1, 32'd5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
